// File: rtl/spi_reg_target.sv
// spi_reg_target: SPI mode-0 register target. The SPI pins are oversampled in
// the c domain, frames of {addr, R/W, data} are decoded MSB first, and a
// single-cycle read/write port to an external register file is driven.
module spi_reg_target #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int N  = ADDR_W + 1 + DATA_W;
    localparam int CW = $clog2(N + 1);
    // Bit count just before the R/W rise and just before the final rise
    localparam logic [CW-1:0] CNT_RW   = CW'(ADDR_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_e;

    // Synchronizer and edge-detect flops
    logic       cs_s1_q, cs_s2_q, cs_d_q;
    logic       sck_s1_q, sck_s2_q, sck_d_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] settle_q;
    logic       armed_q;

    // Frame state
    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]  sr_q, sr_d;
    logic               rw_q, rw_d;
    logic [DATA_W-2:0]  wsh_q, wsh_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic               ld_q, ld_d;

    // Registered outputs
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    logic sck_rise, sck_fall, cs_rise, cs_fall, wr_pre;

    // Two-flop synchronizers plus one delay stage for edge detection. After
    // reset the CS synchronizer holds a fake "high" that would look like a
    // falling edge if CS is already low, so falling edges are only honoured
    // once CS has really been observed high (armed).
    always_ff @(posedge c) begin
        if (!rst_n) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_d_q    <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_d_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            settle_q  <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            cs_s1_q   <= spi_cs;
            cs_s2_q   <= cs_s1_q;
            cs_d_q    <= cs_s2_q;
            sck_s1_q  <= spi_sck;
            sck_s2_q  <= sck_s1_q;
            sck_d_q   <= sck_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            settle_q  <= {settle_q[0], 1'b1};
            if (settle_q[1] && cs_s2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_s2_q & ~sck_d_q;
    assign sck_fall = ~sck_s2_q & sck_d_q;
    assign cs_rise  = cs_s2_q & ~cs_d_q;
    assign cs_fall  = armed_q & cs_d_q & ~cs_s2_q;

    // The final rise of a write frame is visible one cycle early in the first
    // synchronizer stage; registering from there puts reg_wr in the same cycle
    // the synchronized rise is seen. CS going high next cycle cancels it.
    assign wr_pre = (state_q == S_DATA) && rw_q && (cnt_q == CNT_LAST) &&
                    sck_s1_q && !sck_s2_q && !cs_s1_q && !cs_s2_q;

    // Frame state and output registers
    always_ff @(posedge c) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            rw_q    <= 1'b0;
            wsh_q   <= '0;
            tx_q    <= '0;
            ld_q    <= 1'b0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            rw_q    <= rw_d;
            wsh_q   <= wsh_d;
            tx_q    <= tx_d;
            ld_q    <= ld_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Next-state decode: frame sequencing, shifting and strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        rw_d    = rw_q;
        wsh_d   = wsh_q;
        tx_d    = tx_q;
        ld_d    = rd_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        // Read data is valid the cycle after the strobe cycle
        if (ld_q) begin
            tx_d = reg_rdata;
        end

        if (wr_pre) begin
            wr_d    = 1'b1;
            wdata_d = {wsh_q, mosi_s1_q};
        end

        unique case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    sr_d    = '0;
                    wsh_d   = '0;
                    oe_d    = 1'b1;
                    miso_d  = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (sck_rise) begin
                    sr_d  = {sr_q[ADDR_W-2:0], mosi_s2_q};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_RW) begin
                        addr_d  = sr_q;
                        rw_d    = mosi_s2_q;
                        rd_d    = !mosi_s2_q;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (sck_rise) begin
                    cnt_d = cnt_q + CW'(1);
                    if (rw_q) begin
                        wsh_d = {wsh_q[DATA_W-3:0], mosi_s2_q};
                    end
                    if (cnt_q == CNT_LAST) begin
                        miso_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end else if (sck_fall && !rw_q) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            S_DONE: begin
                if (cs_rise) begin
                    done_d  = 1'b1;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign reg_addr    = addr_q;
    assign reg_rd      = rd_q;
    assign reg_wr      = wr_q;
    assign reg_wdata   = wdata_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: doc/spi_reg_target.md
Name: spi_reg_target

Overview:
- SPI responder (target) that terminates the same 4-wire register protocol our camera/IMU SPI masters drive on cam_cs/cam_sck/cam_mosi/cam_miso.
- Oversamples SCK/CS/MOSI in the system clock domain and decodes address/R-W/data frames.
- Issues single-cycle reads and writes to an external register file, and shifts read data back on MISO.
- Used as an in-FPGA sensor model for loopback bring-up, and as the config port of downstream boards.

Parameters:
- ADDR_W, 9, address bits per frame.
- DATA_W, 16, data bits per frame.

Ports:
- c  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- spi_cs  input  1  chip select, active-low, asynchronous to c.
- spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to c.
- spi_mosi  input  1  master-out data, MSB first.
- spi_miso  output  1  target-out data.
- spi_miso_oe  output  1  MISO output enable for the pad tristate.
- reg_addr  output  ADDR_W  register address; held from frame decode until the next frame.
- reg_rd  output  1  one-cycle read strobe.
- reg_rdata  input  DATA_W  register read data; valid exactly 1 cycle after reg_rd.
- reg_wr  output  1  one-cycle write strobe.
- reg_wdata  output  DATA_W  write data; valid when reg_wr=1, then held.
- frame_done  output  1  one-cycle pulse when a complete frame has ended.
- frame_abort  output  1  one-cycle pulse when CS deasserts mid-frame.

Behaviour:
- Input sync: spi_cs, spi_sck and spi_mosi each pass through a 2-flop synchronizer. The synchronizer flops reset to spi_cs=1, spi_sck=0, spi_mosi=0.
- Edge detect: a delayed copy of synchronized SCK gives rise/fall pulses.
- Timing requirement: SCK high and low times must each be at least 4 c cycles. Faster SCK is unsupported.
- Frame format: ADDR_W address bits, then 1 R/W bit (1 = write, 0 = read), then DATA_W data bits; every field MSB first. Total N = ADDR_W+1+DATA_W bits.
- Reset values: spi_miso=0, spi_miso_oe=0, reg_addr=0, reg_rd=0, reg_wr=0, reg_wdata=0, frame_done=0, frame_abort=0. State is IDLE and the bit counter is 0.
- IDLE:
  - Synchronized CS falling: clear the bit counter and shift register, set spi_miso_oe=1, go to ADDR.
  - SCK edges while CS is high are ignored.
- ADDR:
  - Each SCK rise shifts mosi into the shift register and increments the counter.
  - On the rise where the counter reaches ADDR_W+1: latch reg_addr and the R/W bit, go to DATA.
  - If R/W=0, pulse reg_rd on the next cycle; the cycle after that, load reg_rdata into the tx shift register.
- DATA, read:
  - Each SCK fall drives spi_miso from the tx shift register MSB, then shifts left.
  - The first fall after the R/W bit drives data bit DATA_W-1.
  - mosi is still sampled on SCK rises but discarded.
- DATA, write:
  - mosi is shifted into a data register on each SCK rise.
  - On the N-th rise: reg_wdata is set to the assembled word and reg_wr pulses for exactly 1 cycle in the same cycle.
- End of data: after the N-th rise, go to DONE.
- DONE: further SCK edges are ignored, spi_miso is held 0, and no further strobes are issued.
- CS rise:
  - From DONE: pulse frame_done.
  - From ADDR or DATA: pulse frame_abort with no reg_wr. A reg_rd already issued is not retracted.
  - In all cases: spi_miso_oe=0, spi_miso=0, state IDLE, same cycle as the synchronized CS rise.
- Outside read DATA: spi_miso=0 while spi_miso_oe=1.
- Back-to-back frames: a CS fall in the cycle after the frame_done pulse starts a new frame normally. Idle gaps of 0 SCK periods are legal provided CS is high for at least 3 c cycles.
- Reset mid-frame: rst_n low for 1 cycle returns every output to its reset value. The in-progress frame is dropped silently, with no strobe and no frame_abort. A new frame is recognized only after a fresh CS falling edge.
- Simultaneous events: CS rise and SCK edge in the same synchronized cycle means CS wins and the edge is ignored.
- Latency (ADDR_W=9): reg_rd rises 1 c cycle after the synchronized 10th SCK rise; reg_wr rises in the cycle of the synchronized 26th SCK rise.

Test Plan:
- Write: ADDR_W=9, DATA_W=16, SCK half-period 5 cycles. Send addr 0x0A5, W=1, data 0xBEEF → exactly one reg_wr with reg_addr=0x0A5 and reg_wdata=0xBEEF, then one frame_done after CS rise; reg_rd never asserts.
- Read: send addr 0x1F0, R/W=0; bench returns reg_rdata=0x1234 one cycle after reg_rd → exactly one reg_rd with reg_addr=0x1F0. MISO sampled on the 16 SCK rises reads 0x1234, then frame_done. spi_miso_oe is 1 only while CS is low.
- Abort: CS rises after 20 of 26 bits on a write to 0x003 → frame_abort pulses once, no reg_wr, no frame_done. An immediate full write frame to 0x004 data 0x0001 completes normally.
- Extra clocks: write frame followed by 6 extra SCK periods with mosi=1 before CS rise → single reg_wr with the correct data, and spi_miso stays 0.
- Reset mid-frame: pull rst_n low for 1 cycle after 12 bits of a read → all outputs return to 0 and no frame_abort. A following read of 0x000 with rdata 0xA5A5 returns 0xA5A5.
- Back-to-back: three frames (write 0x010 = 0x00FF, read 0x010, write 0x1FF = 0xFFFF) with a 3-cycle CS-high gap → correct strobes in order and 3 frame_done pulses.
